up_uart_tx: RTL and testbench



---
 rtl/up_uart_pkg.sv | 20 ++
 rtl/up_uart_tx_if.sv | 9 +
 rtl/up_baud_counter.sv | 27 ++
 rtl/up_uart_tx.sv | 124 ++++++++++++
 tb/tb_up_uart_tx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/up_uart_pkg.sv
// Shared types and constants for the up_uart_tx serial transmit stage.
package up_uart_pkg;

    localparam int UP_UART_CLKS_PER_BIT_DEFAULT = 434;
    localparam int UP_UART_FRAME_BITS_8N1       = 10;
    localparam int UP_UART_FRAME_BITS_8E1       = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/up_uart_tx_if.sv
// Byte/strobe handshake between the memory-mapped UART port and the transmit stage.
interface up_uart_tx_if;
    logic       transmit;
    logic [7:0] load_out;
    logic       busy_tx;

    modport master (output transmit, output load_out, input busy_tx);
    modport slave  (input transmit, input load_out, output busy_tx);
endinterface

// File: rtl/up_baud_counter.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, tick on the last cycle of each bit.
module up_baud_counter #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/up_uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register.
// Define UP_UART_TX_PARITY_EN to add an even parity bit (8E1 frames).
//
// state     | meaning
// ST_IDLE   | line idle, waiting for a queued byte
// ST_START  | start bit (line low)
// ST_DATA   | eight data bits, LSB first
// ST_PARITY | even parity bit (parity build only)
// ST_STOP   | stop bit; chains straight into the next start if a byte is queued
module up_uart_tx
    import up_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UP_UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    up_uart_tx_if.slave  bus,
    output logic         tx
);
    uart_state_t state;
    logic [7:0]  hold_data;
    logic        hold_valid;
    logic [7:0]  shifter;
    logic [2:0]  bit_idx;
    logic        tick;
    logic        reload;
`ifdef UP_UART_TX_PARITY_EN
    logic        parity_bit;
`endif

    up_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state == ST_IDLE),
        .tick  (tick)
    );

    // Capture needs hold_valid=0, reload needs hold_valid=1, so they never collide.
    assign reload      = hold_valid && ((state == ST_IDLE) || (state == ST_STOP && tick));
    assign bus.busy_tx = hold_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            shifter    <= '0;
            bit_idx    <= '0;
            tx         <= 1'b1;
`ifdef UP_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (bus.transmit && !hold_valid) begin
                hold_data  <= bus.load_out;
                hold_valid <= 1'b1;
            end

            if (reload) begin
                shifter    <= hold_data;
                hold_valid <= 1'b0;
`ifdef UP_UART_TX_PARITY_EN
                parity_bit <= even_parity(hold_data);
`endif
            end

            case (state)
                ST_IDLE: begin
                    if (hold_valid) begin
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx    <= shifter[0];
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shifter <= {1'b0, shifter[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UP_UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= ST_PARITY;
`else
                            tx    <= 1'b1;
                            state <= ST_STOP;
`endif
                        end else begin
                            tx <= shifter[1];
                        end
                    end
                end
`ifdef UP_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        tx    <= 1'b1;
                        state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick) begin
                        if (hold_valid) begin
                            tx    <= 1'b0;
                            state <= ST_START;
                        end else begin
                            tx    <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_up_uart_tx.sv
// Directed and scoreboard bench for up_uart_tx with CLKS_PER_BIT = 4.
module tb_up_uart_tx;
    import up_uart_pkg::*;

    localparam int CPB = 4;
`ifdef UP_UART_TX_PARITY_EN
    localparam int NBITS = UP_UART_FRAME_BITS_8E1;
`else
    localparam int NBITS = UP_UART_FRAME_BITS_8N1;
`endif
    localparam int FLEN = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    up_uart_tx_if bus ();

    up_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    logic [7:0]  rx_q[$];
    int unsigned start_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: decodes frames by sampling the middle of each bit time.
    initial begin
        logic [7:0]  val;
        bit          abort;
        int unsigned st;
        int          b;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && tx === 1'b0) begin
                st    = cyc;
                val   = '0;
                abort = 1'b0;
                for (int k = 1; k <= (NBITS - 1) * CPB + CPB / 2; k++) begin
                    @(negedge clk);
                    if (rst !== 1'b0) begin
                        abort = 1'b1;
                        break;
                    end
                    if (k % CPB == CPB / 2) begin
                        b = k / CPB;
                        if (b == 0) begin
                            n_checks++;
                            if (tx !== 1'b0) begin
                                n_fail++;
                                $display("FAIL mon_start: tx=%b required 0", tx);
                            end
                        end else if (b <= 8) begin
                            val[b-1] = tx;
                        end else if (b == NBITS - 1) begin
                            n_checks++;
                            if (tx !== 1'b1) begin
                                n_fail++;
                                $display("FAIL mon_stop: tx=%b required 1", tx);
                            end
                        end else begin
                            n_checks++;
                            if (tx !== ^val) begin
                                n_fail++;
                                $display("FAIL mon_parity: tx=%b required %b (byte %h)", tx, ^val, val);
                            end
                        end
                    end
                end
                if (!abort) begin
                    rx_q.push_back(val);
                    start_q.push_back(st);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.transmit = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rx_q.delete();
        start_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.transmit = 1'b0;
        bus.load_out = 8'h00;
        repeat (2) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_tx: tx=%b required 1", tx);
        end
        n_checks++;
        if (bus.busy_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: busy_tx=%b required 0", bus.busy_tx);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (tx !== 1'b1 || bus.busy_tx !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: tx=%b busy_tx=%b required 1/0", tx, bus.busy_tx);
        end
    endtask

    task automatic test_single_byte();
        logic [NBITS-1:0] exp_frame;
        logic exp_tx;
        int   busy_cnt = 0;
`ifdef UP_UART_TX_PARITY_EN
        exp_frame = 11'b1_0_10101010_0;
`else
        exp_frame = 10'b1_10101010_0;
`endif
        do_reset();
        for (int t = 0; t < FLEN + 12; t++) begin
            @(negedge clk);
            if (t == 0) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'hAA;
            end else begin
                bus.transmit = 1'b0;
            end
            if (bus.busy_tx === 1'b1) busy_cnt++;
            if (t == 1) begin
                n_checks++;
                if (bus.busy_tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL single_busy_n1: busy_tx=%b required 1", bus.busy_tx);
                end
            end
            exp_tx = (t >= 2 && t < 2 + FLEN) ? exp_frame[(t - 2) / CPB] : 1'b1;
            n_checks++;
            if (tx !== exp_tx) begin
                n_fail++;
                $display("FAIL single_tx t=%0d: tx=%b required %b", t, tx, exp_tx);
            end
        end
        n_checks++;
        if (busy_cnt != 1) begin
            n_fail++;
            $display("FAIL single_busy_len: busy cycles=%0d required 1", busy_cnt);
        end
        n_checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hAA) begin
            n_fail++;
            $display("FAIL single_rx: count=%0d first=%h required 1/aa", rx_q.size(),
                     (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        do_reset();
        for (int t = 0; t < 2 * FLEN + 16; t++) begin
            @(negedge clk);
            bus.transmit = 1'b0;
            if (t == 0) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h55;
            end else if (t == 14) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h0F;
            end
            exp_busy = (t == 1) || (t >= 15 && t < 2 + FLEN);
            n_checks++;
            if (bus.busy_tx !== exp_busy) begin
                n_fail++;
                $display("FAIL b2b_busy t=%0d: busy_tx=%b required %b", t, bus.busy_tx, exp_busy);
            end
            if (t == 1 + FLEN || t == 2 + FLEN) begin
                n_checks++;
                if (tx !== (t == 1 + FLEN)) begin
                    n_fail++;
                    $display("FAIL b2b_gap t=%0d: tx=%b required %b", t, tx, (t == 1 + FLEN));
                end
            end
        end
        n_checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h55 || rx_q[1] !== 8'h0F) begin
            n_fail++;
            $display("FAIL b2b_rx: count=%0d required 2 bytes 55,0f", rx_q.size());
        end
        n_checks++;
        if (start_q.size() != 2 || start_q[1] - start_q[0] != FLEN) begin
            n_fail++;
            $display("FAIL b2b_spacing: starts=%0d delta=%0d required %0d",
                     start_q.size(), (start_q.size() == 2) ? start_q[1] - start_q[0] : 0, FLEN);
        end
    endtask

    task automatic test_dropped_strobe();
        logic exp_busy;
        do_reset();
        for (int t = 0; t < 3 * FLEN; t++) begin
            @(negedge clk);
            bus.transmit = 1'b0;
            if (t == 0) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h01;
            end else if (t == 4) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h02;
            end else if (t == 10) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h03;
            end
            exp_busy = (t == 1) || (t >= 5 && t < 2 + FLEN);
            n_checks++;
            if (bus.busy_tx !== exp_busy) begin
                n_fail++;
                $display("FAIL drop_busy t=%0d: busy_tx=%b required %b", t, bus.busy_tx, exp_busy);
            end
        end
        n_checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h01 || rx_q[1] !== 8'h02) begin
            n_fail++;
            $display("FAIL drop_rx: count=%0d required 2 bytes 01,02", rx_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int low_cnt = 0;
        do_reset();
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            bus.transmit = 1'b0;
            if (t == 0) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'hFF;
            end else if (t == 4) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h11;
            end else if (t == 14) begin
                n_checks++;
                if (bus.busy_tx !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rstmid_queued: busy_tx=%b required 1", bus.busy_tx);
                end
                rst = 1'b1;
            end else if (t == 15) begin
                rst = 1'b0;
                n_checks++;
                if (tx !== 1'b1 || bus.busy_tx !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rstmid_after: tx=%b busy_tx=%b required 1/0", tx, bus.busy_tx);
                end
            end
            if (t > 15 && tx !== 1'b1) low_cnt++;
        end
        n_checks++;
        if (low_cnt != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: low cycles=%0d required 0", low_cnt);
        end
        n_checks++;
        if (rx_q.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_rx: frames=%0d required 0", rx_q.size());
        end
    endtask

`ifdef UP_UART_TX_PARITY_EN
    task automatic test_parity();
        logic exp_tx;
        do_reset();
        for (int t = 0; t < 2 * FLEN + 16; t++) begin
            @(negedge clk);
            bus.transmit = 1'b0;
            if (t == 0) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h07;
            end else if (t == 6) begin
                bus.transmit = 1'b1;
                bus.load_out = 8'h00;
            end
            if (t >= 34 && t < 48) begin
                exp_tx = (t >= 38 && t < 46);
                n_checks++;
                if (tx !== exp_tx) begin
                    n_fail++;
                    $display("FAIL parity_tx t=%0d: tx=%b required %b", t, tx, exp_tx);
                end
            end
        end
        n_checks++;
        if (start_q.size() != 2 || start_q[1] - start_q[0] != 44) begin
            n_fail++;
            $display("FAIL parity_len: starts=%0d required 2 frames 44 apart", start_q.size());
        end
        n_checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'h07 || rx_q[1] !== 8'h00) begin
            n_fail++;
            $display("FAIL parity_rx: count=%0d required 2 bytes 07,00", rx_q.size());
        end
    endtask
`endif

    task automatic test_sweep();
        logic [7:0]  exp_q[$];
        logic [7:0]  d;
        logic        exp_busy;
        int          gap;
        int          t = 0;
        int          hold_from = 0;
        int          release_t = 0;
        int          cur_end = 0;
        int          f;
        int          bad = 0;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            gap = int'($urandom_range(1, 60));
            repeat (gap) begin
                @(negedge clk);
                bus.transmit = 1'b0;
                t++;
            end
            d = 8'($urandom_range(0, 255));
            exp_busy = (t >= hold_from && t < release_t);
            n_checks++;
            if (bus.busy_tx !== exp_busy) begin
                n_fail++;
                $display("FAIL sweep_busy i=%0d: busy_tx=%b required %b", i, bus.busy_tx, exp_busy);
            end
            bus.transmit = 1'b1;
            bus.load_out = d;
            if (!exp_busy) begin
                f         = (t + 2 > cur_end) ? t + 2 : cur_end;
                hold_from = t + 1;
                release_t = f;
                cur_end   = f + FLEN;
                exp_q.push_back(d);
            end
        end
        @(negedge clk);
        bus.transmit = 1'b0;
        for (int w = 0; w < 4000 && rx_q.size() < exp_q.size(); w++) @(negedge clk);
        repeat (2 * FLEN) @(negedge clk);
        n_checks++;
        if (rx_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL sweep_count: received=%0d required %0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            if (rx_q[i] !== exp_q[i]) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL sweep_data: mismatched bytes=%0d required 0", bad);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.transmit = 1'b0;
        bus.load_out = 8'h00;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_dropped_strobe();
        test_reset_mid_frame();
`ifdef UP_UART_TX_PARITY_EN
        test_parity();
`endif
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
